// File: rtl/fcweight_load_ctrl_pkg.sv
// Shared constants, FSM encoding and a constant log2 helper for the FC weight loader.
// Optional feature macro used by the top: FCW_LOAD_CHECKSUM_EN.
package fcweight_load_ctrl_pkg;

    localparam int BW                 = 8;
    localparam int SIZE               = 5;
    localparam int CI                 = 12;
    localparam int CO                 = 10;
    localparam int FC_WEIGHT_N        = CI * CO * SIZE * SIZE;
    localparam int FC_WEIGHT_ROM_BASE = 0;
    localparam int FC_SEAL_TMO        = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SEAL  = 3'd3,
        ST_DONE  = 3'd4
    } fcw_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fcweight_load_ctrl_if.sv
// ROM read port plus FC weight buffer write port, seen from the loader (master)
// and from the ROM/buffer side (slave).
interface fcweight_load_ctrl_if #(
    parameter int AW = 12,
    parameter int BW = 8
);
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [BW-1:0] rom_data;
    logic          buf_ce;
    logic [BW-1:0] buf_data;
    logic          buf_clr;
    logic          buf_full;

    modport master (
        output rom_rd, rom_addr, buf_ce, buf_data, buf_clr,
        input  rom_data, buf_full
    );

    modport slave (
        input  rom_rd, rom_addr, buf_ce, buf_data, buf_clr,
        output rom_data, buf_full
    );
endinterface

// File: rtl/fcweight_load_ctrl_rd_pipe.sv
// One-stage read-to-write register: a ROM read becomes a buffer write one cycle
// later, carrying the ROM data of that cycle. i_kill drops the pending write.
module fcweight_rd_pipe #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          global_rst_n,
    input  logic          i_rd,
    input  logic          i_kill,
    input  logic [BW-1:0] i_rom_data,
    output logic          o_ce,
    output logic [BW-1:0] o_data
);

    logic r_vld;

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) r_vld <= 1'b0;
        else               r_vld <= i_rd && !i_kill;
    end

    // The kill also masks the write already in flight during the kill cycle.
    assign o_ce   = r_vld && !i_kill;
    assign o_data = r_vld ? i_rom_data : '0;

endmodule

// File: rtl/fcweight_load_ctrl.sv
// Sequencer filling the FC weight buffer from the weight ROM, then sealing it.
// Define FCW_LOAD_CHECKSUM_EN to add o_checksum (signed sum of written words).
module fcweight_load_ctrl
    import fcweight_load_ctrl_pkg::*;
#(
    parameter  int BW       = fcweight_load_ctrl_pkg::BW,
    parameter  int SIZE     = fcweight_load_ctrl_pkg::SIZE,
    parameter  int CI       = fcweight_load_ctrl_pkg::CI,
    parameter  int CO       = fcweight_load_ctrl_pkg::CO,
    parameter  int ROM_BASE = FC_WEIGHT_ROM_BASE,
    parameter  int SEAL_TMO = FC_SEAL_TMO,
    localparam int N        = CI * CO * SIZE * SIZE,
    localparam int AW       = clog2(ROM_BASE + N),
    localparam int CW       = clog2(N + 1)
) (
    input  logic                   clk,
    input  logic                   global_rst_n,
    input  logic                   i_start,
    input  logic                   i_process_end,
    input  logic                   i_stall,
    fcweight_load_ctrl_if.master   bus,
`ifdef FCW_LOAD_CHECKSUM_EN
    output logic signed [BW+CW-1:0] o_checksum,
`endif
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);

    localparam int TW = clog2(SEAL_TMO + 1);

    fcw_state_e    r_state, w_state_nxt;
    logic [CW-1:0] r_rd_cnt, r_wr_cnt;
    logic [AW-1:0] r_addr;
    logic [TW-1:0] r_tmo;
    logic          r_err, r_clr;
    logic          w_rd, w_seal_ce, w_tmo_hit, w_pipe_ce, w_wr_word;
    logic [BW-1:0] w_pipe_data;

    assign w_tmo_hit = (r_state == ST_SEAL) && !bus.buf_full && (r_tmo == TW'(SEAL_TMO - 1));
    assign w_wr_word = w_pipe_ce && (r_wr_cnt != CW'(N));

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) r_state <= ST_IDLE;
        else               r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_seal_ce   = 1'b0;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_rd = !i_stall;
                if (!i_stall && (r_rd_cnt == CW'(N - 1))) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: w_state_nxt = ST_SEAL;
            // Keep strobing zeros until the buffer confirms full or we give up.
            ST_SEAL: begin
                w_seal_ce = !bus.buf_full;
                if (bus.buf_full || w_tmo_hit) w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (i_process_end) begin
            w_state_nxt = ST_IDLE;
            w_rd        = 1'b0;
            w_seal_ce   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_addr   <= AW'(ROM_BASE);
            r_tmo    <= '0;
            r_err    <= 1'b0;
            r_clr    <= 1'b0;
        end else begin
            r_clr <= i_process_end;
            if (i_process_end) begin
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
                r_addr   <= AW'(ROM_BASE);
                r_tmo    <= '0;
                r_err    <= 1'b0;
            end else begin
                if (w_rd) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                    r_addr   <= r_addr + 1'b1;
                end
                if (w_wr_word) r_wr_cnt <= r_wr_cnt + 1'b1;
                r_tmo <= (r_state == ST_SEAL) ? r_tmo + 1'b1 : '0;
                if (w_tmo_hit) r_err <= 1'b1;
            end
        end
    end

    fcweight_rd_pipe #(.BW(BW)) u_rd_pipe (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .i_rd         (w_rd),
        .i_kill       (i_process_end),
        .i_rom_data   (bus.rom_data),
        .o_ce         (w_pipe_ce),
        .o_data       (w_pipe_data)
    );

`ifdef FCW_LOAD_CHECKSUM_EN
    logic signed [BW+CW-1:0] r_sum;

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n)      r_sum <= '0;
        else if (i_process_end) r_sum <= '0;
        else if (w_wr_word)     r_sum <= r_sum + {{CW{w_pipe_data[BW-1]}}, w_pipe_data};
    end

    assign o_checksum = r_sum;
`endif

    assign bus.rom_rd   = w_rd;
    assign bus.rom_addr = r_addr;
    assign bus.buf_ce   = w_pipe_ce || w_seal_ce;
    assign bus.buf_data = w_pipe_data;
    assign bus.buf_clr  = r_clr;

    assign o_busy = (r_state == ST_LOAD) || (r_state == ST_DRAIN) || (r_state == ST_SEAL);
    assign o_done = (r_state == ST_DONE);
    assign o_err  = r_err;

endmodule

// File: tb/tb_fcweight_load_ctrl.sv
// Directed bench for fcweight_load_ctrl with a ROM model (ROM[a] = a[7:0] or 0xFF)
// and a buffer model that raises full on the first ce after its N-th stored word.
module tb_fcweight_load_ctrl;
    import fcweight_load_ctrl_pkg::*;

    localparam int N  = FC_WEIGHT_N;
    localparam int AW = clog2(FC_WEIGHT_ROM_BASE + N);
    localparam int CW = clog2(N + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic i_start, i_process_end, i_stall;
    logic o_busy, o_done, o_err;
`ifdef FCW_LOAD_CHECKSUM_EN
    logic signed [BW+CW-1:0] o_checksum;
`endif

    fcweight_load_ctrl_if #(.AW(AW), .BW(BW)) bus ();

    fcweight_load_ctrl dut (
        .clk           (clk),
        .global_rst_n  (rst_n),
        .i_start       (i_start),
        .i_process_end (i_process_end),
        .i_stall       (i_stall),
        .bus           (bus),
`ifdef FCW_LOAD_CHECKSUM_EN
        .o_checksum    (o_checksum),
`endif
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    bit   rom_ff;
    bit   tie_low;
    int   buf_cnt;
    logic buf_full_q;

    always @(posedge clk) begin
        if (bus.rom_rd) bus.rom_data <= rom_ff ? 8'hFF : bus.rom_addr[7:0];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt    <= 0;
            buf_full_q <= 1'b0;
        end else if (bus.buf_clr) begin
            buf_cnt    <= 0;
            buf_full_q <= 1'b0;
        end else if (bus.buf_ce) begin
            if (buf_cnt < N) buf_cnt <= buf_cnt + 1;
            else             buf_full_q <= 1'b1;
        end
    end
    assign bus.buf_full = buf_full_q && !tie_low;

    int n_cmp, n_err;
    // results of the most recent run_load
    int done_cyc, wr, seal, first_ce, gaps, bad, rd_seen, exp_sum, busy_c1;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the i_start cycle; inputs change 1ns after posedge, outputs sampled at negedge.
    task automatic run_load(input bit do_stall, input int mid_start, input int abort_at);
        int stall_left;
        bit aborted;
        logic [7:0] e;
        stall_left = 0; aborted = 0;
        done_cyc = -1; wr = 0; seal = 0; first_ce = -1; gaps = 0; bad = 0;
        rd_seen = 0; exp_sum = 0; busy_c1 = 0;
        @(posedge clk); #1 i_start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc < 20000 && done_cyc < 0 && !aborted; cyc++) begin
            @(posedge clk); #1;
            i_start = (cyc == mid_start);
            i_stall = 1'b0;
            if (stall_left > 0) begin
                i_stall = 1'b1;
                stall_left--;
            end
            @(negedge clk);
            if (cyc == 1) busy_c1 = o_busy;
            if (bus.rom_rd) begin
                rd_seen++;
                if (do_stall && (rd_seen % 100 == 0) && rd_seen < N) stall_left = 5;
            end
            if (bus.buf_ce) begin
                if (wr < N) begin
                    e = rom_ff ? 8'hFF : 8'(wr);
                    if (bus.buf_data !== e) bad++;
                    exp_sum += int'($signed(e));
                    if (wr == 0) first_ce = cyc;
                    wr++;
                end else begin
                    seal++;
                    if (bus.buf_data !== '0) bad++;
                end
            end else if (wr > 0 && wr < N) begin
                gaps++;
            end
            if (o_done) done_cyc = cyc;
            if (abort_at > 0 && wr == abort_at) aborted = 1;
        end
        i_start = 1'b0;
        i_stall = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        @(posedge clk); #1 i_process_end = 1'b1;
        @(negedge clk);
        chk({tag, "_pe_ce"}, bus.buf_ce, 0);
        @(posedge clk); #1 i_process_end = 1'b0;
        @(negedge clk);
        chk({tag, "_clr"}, bus.buf_clr, 1);
        chk({tag, "_done_clr"}, o_done, 0);
        chk({tag, "_err_clr"}, o_err, 0);
        chk({tag, "_busy"}, o_busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_clr_1cyc"}, bus.buf_clr, 0);
    endtask

    initial begin
        int ce_after;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; i_start = 1'b0; i_process_end = 1'b0; i_stall = 1'b0;
        rom_ff = 0; tie_low = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rd", bus.rom_rd, 0);
        chk("rst_addr", bus.rom_addr, FC_WEIGHT_ROM_BASE);
        chk("rst_ce", bus.buf_ce, 0);
        chk("rst_data", bus.buf_data, 0);
        chk("rst_clr", bus.buf_clr, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
`ifdef FCW_LOAD_CHECKSUM_EN
        chk("rst_checksum", o_checksum, 0);
`endif

        // T1: basic load, done lands N+4 cycles after the start cycle
        run_load(0, 0, 0);
        chk("t1_busy", busy_c1, 1);
        chk("t1_first_ce", first_ce, 2);
        chk("t1_words", wr, N);
        chk("t1_reads", rd_seen, N);
        chk("t1_data", bad, 0);
        chk("t1_gaps", gaps, 0);
        chk("t1_seal_ce", seal, 1);
        chk("t1_done_cyc", done_cyc, N + 4);
        chk("t1_err", o_err, 0);
`ifdef FCW_LOAD_CHECKSUM_EN
        chk("t1_checksum", o_checksum, exp_sum);
`endif
        finish_load("t1");

        // T2: 5 stall cycles after every 100 reads (29 stalls before the last read)
        run_load(1, 0, 0);
        chk("t2_words", wr, N);
        chk("t2_data", bad, 0);
        chk("t2_gaps", gaps, 29 * 5);
        chk("t2_done_cyc", done_cyc, N + 4 + 29 * 5);
        finish_load("t2");

        // T3: abort after 1500 writes
        run_load(0, 0, 1500);
        chk("t3_words", wr, 1500);
        @(posedge clk); #1 i_process_end = 1'b1;
        @(negedge clk);
        chk("t3_pe_ce", bus.buf_ce, 0);
        chk("t3_pe_rd", bus.rom_rd, 0);
        @(posedge clk); #1 i_process_end = 1'b0;
        @(negedge clk);
        chk("t3_clr", bus.buf_clr, 1);
        chk("t3_clr_ce", bus.buf_ce, 0);
        chk("t3_idle", o_busy, 0);
        ce_after = 0;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.buf_ce || bus.rom_rd) ce_after++;
        end
        chk("t3_quiet", ce_after, 0);
        chk("t3_clr_1cyc", bus.buf_clr, 0);
        chk("t3_addr", bus.rom_addr, FC_WEIGHT_ROM_BASE);
        // restart, with a stray i_start during LOAD that must change nothing
        run_load(0, 50, 0);
        chk("t3r_first_ce", first_ce, 2);
        chk("t3r_words", wr, N);
        chk("t3r_data", bad, 0);
        chk("t3r_done_cyc", done_cyc, N + 4);
        finish_load("t3r");

        // T4: start and process_end together in IDLE
        @(posedge clk); #1 i_start = 1'b1; i_process_end = 1'b1;
        @(negedge clk);
        chk("t4_busy_same", o_busy, 0);
        @(posedge clk); #1 i_start = 1'b0; i_process_end = 1'b0;
        @(negedge clk);
        chk("t4_clr", bus.buf_clr, 1);
        chk("t4_busy", o_busy, 0);
        chk("t4_rd", bus.rom_rd, 0);

        // T5: buffer never reports full
        tie_low = 1;
        run_load(0, 0, 0);
        chk("t5_words", wr, N);
        chk("t5_seal_ce", seal, 4);
        chk("t5_done_cyc", done_cyc, N + 2 + 4);
        chk("t5_err", o_err, 1);
        tie_low = 0;
        @(posedge clk); #1 i_start = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 i_start = 1'b0;
        @(negedge clk);
        chk("t5_done_hold", o_done, 1);
        chk("t5_busy_hold", o_busy, 0);
        chk("t5_err_hold", o_err, 1);
        finish_load("t5");

`ifdef FCW_LOAD_CHECKSUM_EN
        // T6: ROM all 0xFF sums to -N
        rom_ff = 1;
        run_load(0, 0, 0);
        chk("t6_data", bad, 0);
        chk("t6_checksum", o_checksum, -N);
        finish_load("t6");
        chk("t6_checksum_clr", o_checksum, 0);
        rom_ff = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
